// File: rtl/onehot_sel_pipe_if.sv
// Channel-select bus: input channels + select + capture handshake, and the registered result handshake.
// No storage; pure signal bundle shared between producer/consumer and onehot_sel_pipe.
// Backpressure is carried by in_ready (driven by the pipe) and out_ready (driven by the consumer).
interface onehot_sel_pipe_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
);
  logic [CHANNELS*WIDTH-1:0] ch_in;
  logic [CHANNELS-1:0]       sel;
  logic                      mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [CHANNELS-1:0]       out_sel;
  logic                      out_valid;
  logic                      out_ready;

  // Producer/consumer side: drives channels, select and both request/consume strobes.
  modport master (
    output ch_in, sel, mode, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  // Pipe side: samples the request, owns the output register.
  modport slave (
    input  ch_in, sel, mode, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/onehot_sel_pipe.sv
// Registered one-hot channel selector with illegal-select counting and a rotating SCAN pointer.
// Latency: 1 clock from accepted beat to out_valid; sel_err pulses 1 clock after an illegal accepted beat.
// Backpressure: one-entry output register; in_ready = !out_valid | out_ready, full throughput, frozen while stalled.
module onehot_sel_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_sel_pipe_if.slave    bus,
  output logic                sel_err,
  output logic [ERR_W-1:0]    err_count,
  output logic [CHANNELS-1:0] scan_ptr
);

  logic [CHANNELS-1:0] eff_sel;
  logic                sel_legal;
  logic                accept;
  logic [WIDTH-1:0]    mux_data;

  // The output slot is free when empty or being drained this cycle; this is the only
  // combinational input-to-output path.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // SCAN mode substitutes the internal pointer for the external select.
  assign eff_sel = bus.mode ? scan_ptr : bus.sel;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign sel_legal = (eff_sel != '0) &&
                     ((eff_sel & (eff_sel - CHANNELS'(1))) == '0);

  // AND-OR mux over the channels; only used when the select is legal, so multi-hot
  // blending never reaches the register.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (eff_sel[k]) begin
        mux_data |= bus.ch_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on a legal accepted beat, otherwise drain when consumed.
  // An illegal beat leaves data/select untouched and only lets a consumed word retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
    end else if (accept && sel_legal) begin
      bus.out_data  <= mux_data;
      bus.out_sel   <= eff_sel;
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Illegal-select pulse and saturating counter; stalled beats are not accepted and never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= accept && !sel_legal;
      if (accept && !sel_legal && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  // SCAN pointer rotates left on each accepted SCAN beat and keeps its value in MANUAL mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= CHANNELS'(1);
    end else if (accept && bus.mode) begin
      scan_ptr <= {scan_ptr[CHANNELS-2:0], scan_ptr[CHANNELS-1]};
    end
  end

endmodule

// File: tb/tb_onehot_sel_pipe.sv
// Bench for onehot_sel_pipe: a 16-channel/8-bit-counter instance and a 4-channel/2-bit-counter
// instance share clock, reset and stimulus; both are compared against an index-based model.
// Directed vector table, hand-written multi-cycle sequences, then randomized traffic.
module tb_onehot_sel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_sel_pipe_if #(.WIDTH(16), .CHANNELS(16)) bus_a ();
  onehot_sel_pipe_if #(.WIDTH(16), .CHANNELS(4))  bus_b ();

  logic        sel_err_a, sel_err_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] ptr_a;
  logic [3:0]  ptr_b;

  onehot_sel_pipe #(.WIDTH(16), .CHANNELS(16), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .sel_err(sel_err_a), .err_count(cnt_a), .scan_ptr(ptr_a)
  );

  onehot_sel_pipe #(.WIDTH(16), .CHANNELS(4), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
    .sel_err(sel_err_b), .err_count(cnt_b), .scan_ptr(ptr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus shared by both instances (instance B sees the low 4 channels / select bits)
  logic        t_mode, t_v, t_r;
  logic [31:0] t_sel;
  logic [15:0] ch [16];
  logic        rdy_a, rdy_b;

  // reference model state, index 0 = instance A, 1 = instance B
  int          chn  [2];
  int          emax [2];
  logic [15:0] m_data  [2];
  logic [31:0] m_sel   [2];
  logic        m_valid [2];
  logic        m_err   [2];
  int          m_cnt   [2];
  int          m_ptr   [2];   // pointer kept as a channel index

  typedef struct {
    logic [15:0] sel;
    logic        mode, v, r;
    logic        rdy;
    logic [15:0] data;
    logic [15:0] osel;
    logic        valid, err;
    logic [7:0]  cnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0; m_sel[d] = '0; m_valid[d] = 1'b0;
      m_err[d] = 1'b0; m_cnt[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [31:0] eff;
    logic        rdy, acc, legal;
    int          idx;
    rdy   = !m_valid[d] || t_r;
    acc   = t_v && rdy;
    eff   = t_mode ? (32'd1 << m_ptr[d]) : (t_sel & ((32'd1 << chn[d]) - 32'd1));
    legal = ($countones(eff) == 1);
    m_err[d] = acc && !legal;
    if (acc && legal) begin
      idx = 0;
      for (int k = 0; k < 32; k++) if (eff[k]) idx = k;
      m_data[d]  = ch[idx];
      m_sel[d]   = eff;
      m_valid[d] = 1'b1;
    end else if (t_r) begin
      m_valid[d] = 1'b0;
    end
    if (acc && !legal && m_cnt[d] < emax[d]) m_cnt[d]++;
    if (acc && t_mode) m_ptr[d] = (m_ptr[d] + 1) % chn[d];
  endtask

  task automatic apply();
    bus_a.mode = t_mode;  bus_b.mode = t_mode;
    bus_a.in_valid = t_v; bus_b.in_valid = t_v;
    bus_a.out_ready = t_r; bus_b.out_ready = t_r;
    bus_a.sel = t_sel[15:0];
    bus_b.sel = t_sel[3:0];
    for (int k = 0; k < 16; k++) bus_a.ch_in[k*16 +: 16] = ch[k];
    bus_b.ch_in = {ch[3], ch[2], ch[1], ch[0]};
  endtask

  task automatic check_all();
    chk("a_data",  32'(bus_a.out_data),  32'(m_data[0]));
    chk("a_sel",   32'(bus_a.out_sel),   m_sel[0]);
    chk("a_valid", 32'(bus_a.out_valid), 32'(m_valid[0]));
    chk("a_err",   32'(sel_err_a),       32'(m_err[0]));
    chk("a_cnt",   32'(cnt_a),           32'(m_cnt[0]));
    chk("a_ptr",   32'(ptr_a),           32'd1 << m_ptr[0]);
    chk("b_data",  32'(bus_b.out_data),  32'(m_data[1]));
    chk("b_sel",   32'(bus_b.out_sel),   m_sel[1]);
    chk("b_valid", 32'(bus_b.out_valid), 32'(m_valid[1]));
    chk("b_err",   32'(sel_err_b),       32'(m_err[1]));
    chk("b_cnt",   32'(cnt_b),           32'(m_cnt[1]));
    chk("b_ptr",   32'(ptr_b),           32'd1 << m_ptr[1]);
  endtask

  // called at posedge+1: drive, check in_ready, clock, advance model, check registers
  task automatic step();
    apply();
    #1;
    rdy_a = bus_a.in_ready;
    rdy_b = bus_b.in_ready;
    chk("a_in_ready", 32'(rdy_a), 32'(!m_valid[0] || t_r));
    chk("b_in_ready", 32'(rdy_b), 32'(!m_valid[1] || t_r));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic set_in(input logic mode, input logic [31:0] sel, input logic v, input logic r);
    t_mode = mode; t_sel = sel; t_v = v; t_r = r;
  endtask

  logic [15:0] scan_exp_data [5];
  logic [3:0]  scan_exp_ptr  [5];
  logic [1:0]  sat_exp [5];
  int          rsel;

  initial begin
    chn[0] = 16; chn[1] = 4; emax[0] = 255; emax[1] = 3;
    for (int k = 0; k < 16; k++) ch[k] = 16'hA000 | 16'(k);
    ch[0] = 16'h8000; ch[1] = 16'h4400; ch[2] = 16'h4600; ch[3] = 16'h040C;
    ch[10] = 16'h0470;

    tbl[0] = '{16'h0400, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0470, 16'h0400, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0470, 16'h0400, 1'b0, 1'b1, 8'd1};
    tbl[2] = '{16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0470, 16'h0400, 1'b0, 1'b1, 8'd2};
    tbl[3] = '{16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0470, 16'h0400, 1'b0, 1'b0, 8'd2};
    tbl[4] = '{16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA005, 16'h0020, 1'b1, 1'b0, 8'd2};
    tbl[5] = '{16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA005, 16'h0020, 1'b1, 1'b0, 8'd2};
    tbl[6] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA005, 16'h0020, 1'b1, 1'b0, 8'd2};
    tbl[7] = '{16'h0080, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA007, 16'h0080, 1'b1, 1'b0, 8'd2};
    tbl[8] = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA007, 16'h0080, 1'b0, 1'b0, 8'd2};
    tbl[9] = '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA00F, 16'h8000, 1'b1, 1'b0, 8'd2};

    scan_exp_data = '{16'h8000, 16'h4400, 16'h4600, 16'h040C, 16'h8000};
    scan_exp_ptr  = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    sat_exp       = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // power-up reset
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vector table (expectations for the 16-channel instance)
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].mode, 32'(tbl[i].sel), tbl[i].v, tbl[i].r);
      step();
      chk("tbl_in_ready", 32'(rdy_a),           32'(tbl[i].rdy));
      chk("tbl_data",     32'(bus_a.out_data),  32'(tbl[i].data));
      chk("tbl_sel",      32'(bus_a.out_sel),   32'(tbl[i].osel));
      chk("tbl_valid",    32'(bus_a.out_valid), 32'(tbl[i].valid));
      chk("tbl_err",      32'(sel_err_a),       32'(tbl[i].err));
      chk("tbl_cnt",      32'(cnt_a),           32'(tbl[i].cnt));
    end

    // mid-stream reset, not edge-aligned; the in-flight word must vanish at once
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    apply();
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SCAN sequence with wrap on the 4-channel instance
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'd0, 1'b1, 1'b1);
      step();
      chk("scan_data", 32'(bus_b.out_data), 32'(scan_exp_data[i]));
      chk("scan_ptr",  32'(ptr_b),          32'(scan_exp_ptr[i]));
    end

    // mode switch: move pointer to 4, two MANUAL beats, back to SCAN selects channel 2
    set_in(1'b1, 32'd0, 1'b1, 1'b1);
    step();
    chk("sw_ptr_pre", 32'(ptr_b), 32'h4);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 32'h1, 1'b1, 1'b1);
      step();
      chk("sw_man_data", 32'(bus_b.out_data), 32'h8000);
      chk("sw_man_ptr",  32'(ptr_b),          32'h4);
    end
    set_in(1'b1, 32'd0, 1'b1, 1'b1);
    step();
    chk("sw_scan_data", 32'(bus_b.out_data), 32'h4600);
    chk("sw_scan_ptr",  32'(ptr_b),          32'h8);

    // backpressure: stalled beats (including illegal ones) are ignored
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0 ? 1'b1 : 1'b0, (i == 0) ? 32'h2 : ((i == 1) ? 32'h0 : 32'h3), 1'b1, 1'b0);
      step();
      chk("bp_in_ready", 32'(rdy_b),           32'h0);
      chk("bp_data",     32'(bus_b.out_data),  32'h4600);
      chk("bp_ptr",      32'(ptr_b),           32'h8);
      chk("bp_cnt",      32'(cnt_b),           32'h0);
      chk("bp_err",      32'(sel_err_b),       32'h0);
    end
    set_in(1'b1, 32'd0, 1'b1, 1'b1);
    step();
    chk("bp_rel_ready", 32'(rdy_b),           32'h1);
    chk("bp_rel_data",  32'(bus_b.out_data),  32'h040C);
    chk("bp_rel_valid", 32'(bus_b.out_valid), 32'h1);
    chk("bp_rel_ptr",   32'(ptr_b),           32'h1);

    // saturation of the 2-bit counter; the 8-bit one keeps counting
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 32'd0, 1'b1, 1'b1);
      step();
      chk("sat_cnt_b", 32'(cnt_b),     32'(sat_exp[i]));
      chk("sat_err_b", 32'(sel_err_b), 32'h1);
    end
    chk("sat_cnt_a", 32'(cnt_a), 32'd5);
    set_in(1'b0, 32'd0, 1'b0, 1'b1);
    step();
    chk("sat_err_idle", 32'(sel_err_b), 32'h0);
    chk("sat_cnt_hold", 32'(cnt_b),     32'h3);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < 16; k++) ch[k] = 16'($urandom);
      end
      rsel = int'($urandom_range(0, 9));
      if (rsel < 6)       t_sel = 32'd1 << $urandom_range(0, 3);
      else if (rsel < 8)  t_sel = 32'd1 << $urandom_range(0, 15);
      else if (rsel == 8) t_sel = 32'd0;
      else                t_sel = 32'($urandom) & 32'hFFFF;
      t_mode = 1'($urandom_range(0, 2) == 0);
      t_v    = 1'($urandom_range(0, 3) != 0);
      t_r    = 1'($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
